flit_credit_injector: RTL and testbench

FLIT_CREDIT_INJECTOR -- requirements
Module: flit_credit_injector

---
 rtl/flit_credit_injector.sv | 79 +++++++
 tb/tb_flit_credit_injector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_credit_injector.sv
// Credit-based flit injector: accepts AXI-Stream flits from upstream and forwards them
// to a NoC router input port while the downstream buffer has free credits.
module flit_credit_injector #(
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic                    axis_tvalid,
    output logic                    axis_tready,
    input  logic [FLIT_WIDTH-1:0]   axis_tdata,
    input  logic                    axis_tlast,
    input  logic [DEST_WIDTH-1:0]   axis_tdest,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    pkt_active,
    output logic                    credit_overflow
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BODY = 1'b1;

    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] ONE_CREDIT  = CREDIT_WIDTH'(1);

    logic [0:0]            state;
    logic [DEST_WIDTH-1:0] head_dest;
    logic                  transfer;

    // Ready only looks at registered credits, so a returning credit cannot bypass into this cycle.
    assign axis_tready = (credit_count != '0) && !rst_noc_sync;
    assign transfer    = axis_tvalid && axis_tready;
    assign pkt_active  = (state == BODY);

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state           <= IDLE;
            head_dest       <= '0;
            send_out        <= 1'b0;
            data_out        <= '0;
            dest_out        <= '0;
            is_tail_out     <= 1'b0;
            credit_count    <= MAX_CREDITS;
            credit_overflow <= 1'b0;
        end else begin
            send_out <= transfer;

            if (transfer) begin
                data_out    <= axis_tdata;
                is_tail_out <= axis_tlast;
                // Body flits reuse the head's route; their own tdest is ignored.
                if (state == IDLE) begin
                    head_dest <= axis_tdest;
                    dest_out  <= axis_tdest;
                end else begin
                    dest_out  <= head_dest;
                end
                state <= axis_tlast ? IDLE : BODY;
            end

            if (credit_in && !transfer) begin
                if (credit_count == MAX_CREDITS) begin
                    credit_overflow <= 1'b1;
                end else begin
                    credit_count <= credit_count + ONE_CREDIT;
                end
            end else if (transfer && !credit_in) begin
                credit_count <= credit_count - ONE_CREDIT;
            end
        end
    end

endmodule

// File: tb/tb_flit_credit_injector.sv
// Self-checking bench for flit_credit_injector: directed scenarios plus randomized traffic
// compared every cycle against a credit/packet reference model.
module tb_flit_credit_injector;

    localparam int FW    = 128;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_noc = 1'b0;
    logic          rst_noc_sync;
    logic          axis_tvalid;
    logic          axis_tready;
    logic [FW-1:0] axis_tdata;
    logic          axis_tlast;
    logic [DW-1:0] axis_tdest;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in;
    logic [CW-1:0] credit_count;
    logic          pkt_active;
    logic          credit_overflow;

    always #5 clk_noc = ~clk_noc;

    flit_credit_injector #(
        .FLIT_WIDTH(FW),
        .DEST_WIDTH(DW),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc(clk_noc),
        .rst_noc_sync(rst_noc_sync),
        .axis_tvalid(axis_tvalid),
        .axis_tready(axis_tready),
        .axis_tdata(axis_tdata),
        .axis_tlast(axis_tlast),
        .axis_tdest(axis_tdest),
        .data_out(data_out),
        .dest_out(dest_out),
        .is_tail_out(is_tail_out),
        .send_out(send_out),
        .credit_in(credit_in),
        .credit_count(credit_count),
        .pkt_active(pkt_active),
        .credit_overflow(credit_overflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: what the outputs must show after the latest clock edge.
    logic          model_valid = 1'b0;
    logic          exp_send;
    logic [FW-1:0] exp_data;
    logic [DW-1:0] exp_dest;
    logic          exp_tail;
    logic          exp_ovf;
    logic          in_pkt;
    logic [DW-1:0] route;
    int            credits;

    int   send_count = 0;
    logic last_tail  = 1'b0;
    logic acc;
    int   idx;

    task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                               input logic [FW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [FW-1:0] d, input logic last,
                                 input logic [DW-1:0] dst, input logic cr, input logic rs,
                                 output logic accepted);
        axis_tvalid  = v;
        axis_tdata   = d;
        axis_tlast   = last;
        axis_tdest   = dst;
        credit_in    = cr;
        rst_noc_sync = rs;
        #1;
        accepted = v && axis_tready;
        @(posedge clk_noc);
        #1;
    endtask

    task automatic doReset();
        logic a;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, a);
    endtask

    function automatic logic [FW-1:0] rand_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk_noc) begin : ref_model
        logic xfer;
        if (rst_noc_sync) begin
            exp_send    = 1'b0;
            exp_data    = '0;
            exp_dest    = '0;
            exp_tail    = 1'b0;
            exp_ovf     = 1'b0;
            in_pkt      = 1'b0;
            route       = '0;
            credits     = DEPTH;
            model_valid = 1'b1;
        end else if (model_valid) begin
            xfer     = axis_tvalid && (credits > 0);
            exp_send = xfer;
            if (xfer) begin
                if (!in_pkt) route = axis_tdest;
                exp_data = axis_tdata;
                exp_tail = axis_tlast;
                exp_dest = route;
                in_pkt   = !axis_tlast;
            end
            if (credit_in && !xfer && credits == DEPTH) exp_ovf = 1'b1;
            else credits = credits + (credit_in ? 1 : 0) - (xfer ? 1 : 0);
        end
    end

    always @(negedge clk_noc) begin
        if (model_valid) begin
            checkOutput("tready", FW'(axis_tready), FW'((credits > 0) && !rst_noc_sync));
            checkOutput("credit_count", FW'(credit_count), FW'(credits));
            checkOutput("pkt_active", FW'(pkt_active), FW'(in_pkt));
            checkOutput("overflow", FW'(credit_overflow), FW'(exp_ovf));
            checkOutput("send_out", FW'(send_out), FW'(exp_send));
            checkOutput("data_out", data_out, exp_data);
            checkOutput("dest_out", FW'(dest_out), FW'(exp_dest));
            checkOutput("is_tail_out", FW'(is_tail_out), FW'(exp_tail));
            if (send_out) begin
                send_count++;
                last_tail = is_tail_out;
            end
        end
    end

    initial begin
        axis_tvalid  = 1'b0;
        axis_tdata   = '0;
        axis_tlast   = 1'b0;
        axis_tdest   = '0;
        credit_in    = 1'b0;
        rst_noc_sync = 1'b1;
        @(posedge clk_noc);
        #1;
        doReset();
        checkOutput("reset_credits", FW'(credit_count), FW'(4));
        checkOutput("reset_send", FW'(send_out), FW'(0));
        checkOutput("reset_dest", FW'(dest_out), FW'(0));

        // Burst of a 6-flit packet against 4 credits, then two returned credits.
        send_count = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, FW'(idx + 100), idx == 5, 4'h3, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("burst_pulses", FW'(send_count), FW'(4));
        checkOutput("burst_credits", FW'(credit_count), FW'(0));
        checkOutput("burst_tready", FW'(axis_tready), FW'(0));
        applyStimulus(1'b1, FW'(idx + 100), idx == 5, 4'h3, 1'b1, 1'b0, acc);
        checkOutput("no_bypass", FW'(acc), FW'(0));
        applyStimulus(1'b1, FW'(idx + 100), idx == 5, 4'h3, 1'b1, 1'b0, acc);
        if (acc) idx++;
        for (int c = 0; c < 10 && idx < 6; c++) begin
            applyStimulus(1'b1, FW'(idx + 100), idx == 5, 4'h3, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, acc);
        checkOutput("burst_total", FW'(send_count), FW'(6));
        checkOutput("burst_tail", FW'(last_tail), FW'(1));
        checkOutput("burst_tail_data", data_out, FW'(105));
        checkOutput("burst_pkt_done", FW'(pkt_active), FW'(0));

        // Destination lock across a packet.
        doReset();
        applyStimulus(1'b1, rand_flit(), 1'b0, 4'h5, 1'b0, 1'b0, acc);
        checkOutput("lock_head", FW'(dest_out), FW'(4'h5));
        applyStimulus(1'b1, rand_flit(), 1'b0, 4'hA, 1'b0, 1'b0, acc);
        checkOutput("lock_body", FW'(dest_out), FW'(4'h5));
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'hA, 1'b0, 1'b0, acc);
        checkOutput("lock_tail", FW'(dest_out), FW'(4'h5));
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'hA, 1'b0, 1'b0, acc);
        checkOutput("lock_next_head", FW'(dest_out), FW'(4'hA));

        // Simultaneous transfer and credit return, and credit arriving at zero.
        doReset();
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'h1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'h1, 1'b0, 1'b0, acc);
        checkOutput("sim_pre", FW'(credit_count), FW'(2));
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'h1, 1'b1, 1'b0, acc);
        checkOutput("sim_hold", FW'(credit_count), FW'(2));
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'h1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'h1, 1'b0, 1'b0, acc);
        checkOutput("sim_empty", FW'(credit_count), FW'(0));
        applyStimulus(1'b1, rand_flit(), 1'b1, 4'h1, 1'b1, 1'b0, acc);
        checkOutput("sim_zero_ready", FW'(acc), FW'(0));
        checkOutput("sim_next_ready", FW'(axis_tready), FW'(1));

        // Credit overflow is sticky until reset.
        doReset();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
        checkOutput("ovf_count", FW'(credit_count), FW'(4));
        checkOutput("ovf_set", FW'(credit_overflow), FW'(1));
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, acc);
        checkOutput("ovf_sticky", FW'(credit_overflow), FW'(1));
        doReset();
        checkOutput("ovf_cleared", FW'(credit_overflow), FW'(0));

        // Back-to-back single-flit packets.
        for (int d = 1; d <= 3; d++) begin
            applyStimulus(1'b1, rand_flit(), 1'b1, DW'(d), 1'b0, 1'b0, acc);
            checkOutput("single_send", FW'(send_out), FW'(1));
            checkOutput("single_dest", FW'(dest_out), FW'(d));
            checkOutput("single_tail", FW'(is_tail_out), FW'(1));
            checkOutput("single_idle", FW'(pkt_active), FW'(0));
        end

        // Reset in the middle of a packet.
        doReset();
        applyStimulus(1'b1, rand_flit(), 1'b0, 4'h6, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, rand_flit(), 1'b0, 4'h6, 1'b0, 1'b0, acc);
        checkOutput("mid_active", FW'(pkt_active), FW'(1));
        doReset();
        checkOutput("mid_abandon", FW'(pkt_active), FW'(0));
        checkOutput("mid_credits", FW'(credit_count), FW'(4));
        applyStimulus(1'b1, rand_flit(), 1'b0, 4'h7, 1'b0, 1'b0, acc);
        checkOutput("mid_new_head", FW'(dest_out), FW'(4'h7));

        // Randomized traffic, credits and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(9) < 7, rand_flit(), $urandom_range(3) == 0,
                          DW'($urandom), $urandom_range(9) < 3, $urandom_range(63) == 0, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
